cordic_operand_seq: RTL and testbench

Sequencer in front of the CORDIC core. It accepts one or two FP32 operands per request and converts them one after another through a single shared float-to-Q32.32 conversion unit. It registers the fix64 results and presents them, with per-operand range status, to the CORDIC core over a valid/ready handshake. It sits between the CVA6 FU issue interface and the CORDIC iteration engine.

---
 rtl/cordic_operand_seq_if.sv | 35 +++
 rtl/cordic_operand_seq.sv | 166 ++++++++++++++++
 tb/tb_cordic_operand_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_operand_seq_if.sv
// Handshake bundle between the FU issue side and the operand sequencer.
// The request channel flows into the sequencer; the converted-pair channel
// flows out of it towards the CORDIC iteration engine.
interface cordic_operand_seq_if #(
    parameter int TAG_W = 3
);
    // Request channel (issue side -> sequencer)
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_two_op_i;
    logic [31:0]      op_a_i;
    logic [31:0]      op_b_i;
    logic [TAG_W-1:0] tag_i;

    // Converted-pair channel (sequencer -> CORDIC core)
    logic             out_valid_o;
    logic             out_ready_i;
    logic [63:0]      fix_a_o;
    logic [63:0]      fix_b_o;
    logic [1:0]       stat_a_o;
    logic [1:0]       stat_b_o;
    logic [TAG_W-1:0] tag_o;

    // Environment side: issues requests and consumes converted pairs
    modport master (
        output req_valid_i, req_two_op_i, op_a_i, op_b_i, tag_i, out_ready_i,
        input  req_ready_o, out_valid_o, fix_a_o, fix_b_o, stat_a_o, stat_b_o, tag_o
    );

    // Sequencer side
    modport slave (
        input  req_valid_i, req_two_op_i, op_a_i, op_b_i, tag_i, out_ready_i,
        output req_ready_o, out_valid_o, fix_a_o, fix_b_o, stat_a_o, stat_b_o, tag_o
    );
endinterface

// File: rtl/cordic_operand_seq.sv
// Operand sequencer in front of the CORDIC core. Converts one or two FP32
// operands to Q32.32 through a single shared combinational converter,
// registers the results with range status and presents them as one pair.
module cordic_operand_seq #(
    parameter int TAG_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 busy_o,
    cordic_operand_seq_if.slave  bus
);
    localparam int FIX_W = 64;

    localparam logic [1:0] STAT_OK    = 2'b00;
    localparam logic [1:0] STAT_SAT   = 2'b01;
    localparam logic [1:0] STAT_UNDER = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CONV_A,
        CONV_B,
        OUT
    } state_e;

    state_e state_q, state_d;

    logic             accept, cap_a, cap_b, clr_b;
    logic [31:0]      op_a_q, op_b_q;
    logic             two_op_q;
    logic [TAG_W-1:0] tag_q;
    logic [FIX_W-1:0] fix_a_q, fix_b_q;
    logic [1:0]       stat_a_q, stat_b_q;

    logic [31:0]      conv_op;
    logic             conv_sign;
    logic [7:0]       conv_exp;
    logic [22:0]      conv_man;
    logic [FIX_W-1:0] conv_ext, conv_mag, conv_fix;
    logic [1:0]       conv_stat;

    // State register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and per-state control strobes; flush overrides everything
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned and infers a latch.
        state_d         = state_q;
        accept          = 1'b0;
        cap_a           = 1'b0;
        cap_b           = 1'b0;
        clr_b           = 1'b0;
        bus.req_ready_o = 1'b0;
        bus.out_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    accept  = 1'b1;
                    state_d = CONV_A;
                end
            end
            CONV_A: begin
                cap_a = 1'b1;
                if (two_op_q) begin
                    state_d = CONV_B;
                end else begin
                    clr_b   = 1'b1;
                    state_d = OUT;
                end
            end
            CONV_B: begin
                cap_b   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            accept  = 1'b0;
            cap_a   = 1'b0;
            cap_b   = 1'b0;
            clr_b   = 1'b0;
        end
    end

    // Shared FP32 -> Q32.32 converter, fed by whichever operand is in turn
    always_comb begin
        conv_op   = (state_q == CONV_B) ? op_b_q : op_a_q;
        conv_sign = conv_op[31];
        conv_exp  = conv_op[30:23];
        conv_man  = conv_op[22:0];
        conv_ext  = {40'd0, 1'b1, conv_man};
        conv_mag  = '0;
        conv_fix  = '0;
        conv_stat = STAT_OK;
        if (conv_exp == 8'd0) begin
            // zero or denormal: far below one LSB of Q32.32
            conv_stat = (conv_man != 23'd0) ? STAT_UNDER : STAT_OK;
        end else if (conv_exp >= 8'd158) begin
            // |f| >= 2^31 (including Inf/NaN) does not fit the integer part
            conv_fix  = conv_sign ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
            conv_stat = STAT_SAT;
        end else if (conv_exp < 8'd95) begin
            conv_stat = STAT_UNDER;
        end else begin
            // {1,m} carries 23 fraction bits; Q32.32 wants 32, hence bias 127+23-32
            if (conv_exp >= 8'd118) conv_mag = conv_ext << (conv_exp - 8'd118);
            else                    conv_mag = conv_ext >> (8'd118 - conv_exp);
            conv_fix = conv_sign ? (~conv_mag + 64'd1) : conv_mag;
        end
    end

    // Operand capture at accept; these are always written before being read
    always_ff @(posedge clk_i) begin
        // NOTE: the operand holding registers are deliberately left out of
        // reset: the FSM never reads them before an accept has loaded them.
        if (accept) begin
            op_a_q   <= bus.op_a_i;
            op_b_q   <= bus.op_b_i;
            two_op_q <= bus.req_two_op_i;
        end
    end

    // Result and tag registers presented to the CORDIC core
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_q    <= '0;
            fix_a_q  <= '0;
            fix_b_q  <= '0;
            stat_a_q <= STAT_OK;
            stat_b_q <= STAT_OK;
        end else begin
            if (accept) tag_q <= bus.tag_i;
            if (cap_a) begin
                fix_a_q  <= conv_fix;
                stat_a_q <= conv_stat;
            end
            if (cap_b) begin
                fix_b_q  <= conv_fix;
                stat_b_q <= conv_stat;
            end
            if (clr_b) begin
                fix_b_q  <= '0;
                stat_b_q <= STAT_OK;
            end
        end
    end

    assign bus.fix_a_o  = fix_a_q;
    assign bus.fix_b_o  = fix_b_q;
    assign bus.stat_a_o = stat_a_q;
    assign bus.stat_b_o = stat_b_q;
    assign bus.tag_o    = tag_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_cordic_operand_seq.sv
// Self-checking bench for cordic_operand_seq: directed cases with fixed
// expected values plus random operands checked against a real-valued model.
module tb_cordic_operand_seq;
    logic clk_i = 1'b0;
    logic rst_ni;
    logic flush_i;
    logic busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cordic_operand_seq_if #(.TAG_W(3)) bus ();

    cordic_operand_seq #(.TAG_W(3)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Value-level model: interpret the FP32 number as a real, scale by 2^32
    // and truncate toward zero, with saturation/underflow by magnitude.
    function automatic void model_conv(input logic [31:0] f, output logic [63:0] fix,
                                       output logic [1:0] st);
        int     e;
        int     m;
        real    absv;
        longint mag;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 255) begin
            fix = f[31] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            st  = 2'b01;
            return;
        end
        if (e == 0) absv = real'(m) * (2.0 ** (-149.0));
        else        absv = real'(m + (1 << 23)) * (2.0 ** real'(e - 150));
        if (absv == 0.0) begin
            fix = 64'd0;
            st  = 2'b00;
        end else if (absv >= 2.0 ** 31.0) begin
            fix = f[31] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            st  = 2'b01;
        end else if (absv < 2.0 ** (-32.0)) begin
            fix = 64'd0;
            st  = 2'b10;
        end else begin
            mag = longint'($floor(absv * (2.0 ** 32.0)));
            fix = f[31] ? 64'(-mag) : 64'(mag);
            st  = 2'b00;
        end
    endfunction

    // One full transaction: accept, latency, output checks during a hold
    // period with out_ready low, then the consuming handshake.
    task automatic do_req(input string name, input logic two, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] t,
                          input logic [63:0] ea, input logic [63:0] eb,
                          input logic [1:0] sa, input logic [1:0] sb, input int hold);
        int lat;
        @(negedge clk_i);
        check({name, " req_ready"}, 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_two_op_i = two;
        bus.op_a_i       = a;
        bus.op_b_i       = b;
        bus.tag_i        = t;
        @(negedge clk_i);
        bus.req_valid_i  = 1'b0;
        bus.op_a_i       = $urandom;
        bus.op_b_i       = $urandom;
        bus.tag_i        = 3'($urandom);
        lat = 1;
        while (!bus.out_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check({name, " latency"}, 64'(lat), two ? 64'd3 : 64'd2);
        for (int i = 0; i <= hold; i++) begin
            check({name, " out_valid"}, 64'(bus.out_valid_o), 64'd1);
            check({name, " req_ready_in_out"}, 64'(bus.req_ready_o), 64'd0);
            check({name, " fix_a"}, bus.fix_a_o, ea);
            check({name, " fix_b"}, bus.fix_b_o, eb);
            check({name, " stat_a"}, 64'(bus.stat_a_o), 64'(sa));
            check({name, " stat_b"}, 64'(bus.stat_b_o), 64'(sb));
            check({name, " tag"}, 64'(bus.tag_o), 64'(t));
            if (i < hold) @(negedge clk_i);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        bus.out_ready_i = 1'b0;
        check({name, " idle_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({name, " idle_ready"}, 64'(bus.req_ready_o), 64'd1);
        check({name, " idle_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] ea, eb;
        logic [1:0]  sa, sb;
        logic        two;
        int          sel, lat;

        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_two_op_i = 1'b0;
        bus.op_a_i       = '0;
        bus.op_b_i       = '0;
        bus.tag_i        = '0;
        bus.out_ready_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst fix_a", bus.fix_a_o, 64'd0);
        check("rst fix_b", bus.fix_b_o, 64'd0);
        check("rst stats", 64'({bus.stat_a_o, bus.stat_b_o}), 64'd0);
        check("rst tag", 64'(bus.tag_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst req_ready", 64'(bus.req_ready_o), 64'd1);

        // Directed cases with hand-derived expectations
        do_req("two_op", 1'b1, 32'h3F80_0000, 32'hC020_0000, 3'd5,
               64'h0000_0001_0000_0000, 64'hFFFF_FFFD_8000_0000, 2'b00, 2'b00, 0);
        do_req("one_op", 1'b0, 32'h3F00_0000, 32'h4000_0000, 3'd2,
               64'h0000_0000_8000_0000, 64'd0, 2'b00, 2'b00, 0);
        do_req("saturate", 1'b1, 32'h5380_0000, 32'hCF00_0000, 3'd7,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 2'b01, 0);
        do_req("underflow", 1'b1, 32'h2B80_0000, 32'h0000_0001, 3'd3,
               64'd0, 64'd0, 2'b10, 2'b10, 0);
        do_req("neg_zero", 1'b0, 32'h8000_0000, 32'h0000_0001, 3'd1,
               64'd0, 64'd0, 2'b00, 2'b00, 0);
        do_req("hold5", 1'b1, 32'h4049_0FDB, 32'hBF80_0000, 3'd4,
               64'h0000_0003_243F_6C00, 64'hFFFF_FFFF_0000_0000, 2'b00, 2'b00, 5);
        do_req("after_hold", 1'b0, 32'h4000_0000, 32'h0, 3'd6,
               64'h0000_0002_0000_0000, 64'd0, 2'b00, 2'b00, 0);

        // Flush while converting operand B
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_two_op_i = 1'b1;
        bus.op_a_i       = 32'h3F80_0000;
        bus.op_b_i       = 32'h3F80_0000;
        bus.tag_i        = 3'd2;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush in_conv_b busy", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy", 64'(busy_o), 64'd0);
        check("flush req_ready", 64'(bus.req_ready_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("flush no_valid", 64'(bus.out_valid_o), 64'd0);
            @(negedge clk_i);
        end

        // Flush coinciding with a request handshake drops the request
        bus.req_valid_i = 1'b1;
        flush_i         = 1'b1;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        flush_i         = 1'b0;
        check("flush_accept busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk_i);
        check("flush_accept no_valid", 64'(bus.out_valid_o), 64'd0);

        // Reset while presenting a pair
        bus.req_valid_i  = 1'b1;
        bus.req_two_op_i = 1'b0;
        bus.op_a_i       = 32'hC2C8_0000;
        bus.tag_i        = 3'd5;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.out_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check("rst_in_out reached", 64'(bus.out_valid_o), 64'd1);
        check("rst_in_out fix_a", bus.fix_a_o, 64'hFFFF_FF9C_0000_0000);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_in_out out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_in_out busy", 64'(busy_o), 64'd0);
        check("rst_in_out fix_a", bus.fix_a_o, 64'd0);
        check("rst_in_out fix_b", bus.fix_b_o, 64'd0);
        check("rst_in_out stats", 64'({bus.stat_a_o, bus.stat_b_o}), 64'd0);
        check("rst_in_out tag", 64'(bus.tag_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_in_out req_ready", 64'(bus.req_ready_o), 64'd1);

        // Random operands against the value-level model
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 2; k++) begin
                sel = int'($urandom_range(0, 6));
                ra = $urandom;
                case (sel)
                    0:       ra[30:23] = 8'd0;
                    1:       ra[30:23] = 8'd255;
                    2:       ra[30:23] = 8'($urandom_range(80, 100));
                    3:       ra[30:23] = 8'($urandom_range(150, 165));
                    default: ra[30:23] = 8'($urandom_range(95, 157));
                endcase
                if (k == 0) rb = ra;
            end
            two = 1'($urandom);
            model_conv(rb, ea, sa);
            if (two) model_conv(ra, eb, sb);
            else begin
                eb = 64'd0;
                sb = 2'b00;
            end
            do_req($sformatf("rand%0d", n), two, rb, ra, 3'($urandom), ea, eb, sa, sb,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
